// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared encodings for the load/store unit: request opcodes,
//               response exception codes, response-register states and the
//               byte-enable patterns used for store lane steering.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // Request opcodes; bit 3 marks a store, bit 2 marks an unsigned load
  typedef enum logic [3:0] {
    OP_LB  = 4'b0000,
    OP_LH  = 4'b0001,
    OP_LW  = 4'b0010,
    OP_LBU = 4'b0100,
    OP_LHU = 4'b0101,
    OP_SB  = 4'b1000,
    OP_SH  = 4'b1001,
    OP_SW  = 4'b1010
  } lsu_op_e;

  // Response exception codes
  typedef enum logic [1:0] {
    EXC_NONE      = 2'b00,
    EXC_LOAD_MIS  = 2'b01,
    EXC_STORE_MIS = 2'b10,
    EXC_ILLEGAL   = 2'b11
  } lsu_exc_e;

  // Response register occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } lsu_state_e;

  // Byte-enable patterns
  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_WORD    = 4'b1111;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Purely combinational datapath of the load/store unit.
//               Classifies the request (illegal / out of range / misaligned),
//               steers store data onto byte lanes and extracts and extends
//               load data from the returned memory word.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic [3:0]        op,
  input  logic [1:0]        addr_lo,
  input  logic [31:WIDTH]   addr_hi,
  input  logic [31:0]       wdata,
  input  logic [31:0]       rd_word,
  output logic              is_store,
  output logic [1:0]        exc,
  output logic [3:0]        be,
  output logic [31:0]       wd,
  output logic [31:0]       ld_data
);

  logic        legal;
  logic        misaligned;
  logic        out_of_range;
  logic [31:0] shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Opcode decode: legality, direction and alignment requirement
  always_comb begin
    legal      = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    case (op)
      OP_LB, OP_LBU: legal = 1'b1;
      OP_LH, OP_LHU: begin
        legal      = 1'b1;
        misaligned = addr_lo[0];
      end
      OP_LW: begin
        legal      = 1'b1;
        misaligned = |addr_lo;
      end
      OP_SB: begin
        legal    = 1'b1;
        is_store = 1'b1;
      end
      OP_SH: begin
        legal      = 1'b1;
        is_store   = 1'b1;
        misaligned = addr_lo[0];
      end
      OP_SW: begin
        legal      = 1'b1;
        is_store   = 1'b1;
        misaligned = |addr_lo;
      end
      default: legal = 1'b0;
    endcase
  end

  assign out_of_range = |addr_hi;

  // Exception classification; illegal/out-of-range outranks misalignment
  always_comb begin
    exc = EXC_NONE;
    if (!legal || out_of_range) begin
      exc = EXC_ILLEGAL;
    end else if (misaligned) begin
      exc = is_store ? EXC_STORE_MIS : EXC_LOAD_MIS;
    end
  end

  // Store lane steering: data replicated on all lanes, enables pick the lanes
  always_comb begin
    be = BE_NONE;
    wd = 32'h0;
    case (op)
      OP_SB: begin
        be = BE_BYTE0 << addr_lo;
        wd = {4{wdata[7:0]}};
      end
      OP_SH: begin
        be = addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
        wd = {2{wdata[15:0]}};
      end
      OP_SW: begin
        be = BE_WORD;
        wd = wdata;
      end
      default: begin
        be = BE_NONE;
        wd = 32'h0;
      end
    endcase
  end

  // Little-endian lane select of the returned word
  assign shifted = rd_word >> {addr_lo, 3'b000};
  assign ld_byte = shifted[7:0];
  assign ld_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  // Load extension
  always_comb begin
    ld_data = 32'h0;
    case (op)
      OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  ld_data = {24'h0, ld_byte};
      OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  ld_data = {16'h0, ld_half};
      OP_LW:   ld_data = rd_word;
      default: ld_data = 32'h0;
    endcase
  end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : Load/store unit, initiator side of the data-memory port.
//               Accepts one request per cycle, drives the memory write
//               strobe and lanes, and holds one registered response for the
//               writeback stage.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
  import lsu_pkg::*;
#(
  parameter int WIDTH = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_rd,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic [31:0] mem_pc,
  input  logic [31:0] mem_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic [1:0]  rsp_exc,
  output logic [31:0] rsp_badaddr
);

  lsu_state_e  state_q, state_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic [4:0]  rsp_rd_q, rsp_rd_d;
  logic [1:0]  rsp_exc_q, rsp_exc_d;
  logic [31:0] rsp_badaddr_q, rsp_badaddr_d;

  logic        is_store;
  logic [1:0]  exc;
  logic [3:0]  be;
  logic [31:0] ld_data;
  logic        accept;
  logic        faulted;

  lsu_align #(
    .WIDTH (WIDTH)
  ) u_align (
    .op       (req_op),
    .addr_lo  (req_addr[1:0]),
    .addr_hi  (req_addr[31:WIDTH]),
    .wdata    (req_wdata),
    .rd_word  (mem_rd),
    .is_store (is_store),
    .exc      (exc),
    .be       (be),
    .wd       (mem_wd),
    .ld_data  (ld_data)
  );

  assign faulted  = (exc != EXC_NONE);
  assign mem_addr = {2'b00, req_addr[31:2]};
  assign mem_pc   = req_pc;

  // Handshake and write strobe; reset blocks both acceptance and writing
  always_comb begin
    req_ready = (state_q == ST_EMPTY) || rsp_ready;
    accept    = req_valid && req_ready && !reset;
    mem_we    = accept && is_store && !faulted;
    mem_be    = mem_we ? be : BE_NONE;
  end

  // Next response: load on accept, drain when writeback takes it
  always_comb begin
    state_d       = state_q;
    rsp_data_d    = rsp_data_q;
    rsp_rd_d      = rsp_rd_q;
    rsp_exc_d     = rsp_exc_q;
    rsp_badaddr_d = rsp_badaddr_q;
    if (accept) begin
      state_d       = ST_FULL;
      rsp_data_d    = (faulted || is_store) ? 32'h0 : ld_data;
      rsp_rd_d      = (faulted || is_store) ? 5'd0 : req_rd;
      rsp_exc_d     = exc;
      rsp_badaddr_d = faulted ? req_addr : 32'h0;
    end else if ((state_q == ST_FULL) && rsp_ready) begin
      state_d = ST_EMPTY;
    end
  end

  // Response register FSM
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      rsp_data_q    <= 32'h0;
      rsp_rd_q      <= 5'd0;
      rsp_exc_q     <= EXC_NONE;
      rsp_badaddr_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      rsp_data_q    <= rsp_data_d;
      rsp_rd_q      <= rsp_rd_d;
      rsp_exc_q     <= rsp_exc_d;
      rsp_badaddr_q <= rsp_badaddr_d;
    end
  end

  assign rsp_valid   = (state_q == ST_FULL);
  assign rsp_data    = rsp_data_q;
  assign rsp_rd      = rsp_rd_q;
  assign rsp_exc     = rsp_exc_q;
  assign rsp_badaddr = rsp_badaddr_q;

endmodule : lsu
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Self-checking bench for lsu. A bench-side memory answers the
//               DUT port; a separate reference memory and response queue
//               predict every output cycle by cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;

  localparam int WIDTH = 12;
  localparam int WORDS = 1 << (WIDTH - 2);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = 4'h0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [31:0] req_pc = 32'h0;
  logic [4:0]  req_rd = 5'd0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_pc;
  logic [31:0] mem_rd;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic [1:0]  rsp_exc;
  logic [31:0] rsp_badaddr;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic [1:0]  exc;
    logic [31:0] bad;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] env_mem [WORDS];
  logic [31:0] ref_mem [WORDS];

  always #5 clk = ~clk;

  lsu #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_pc      (req_pc),
    .req_rd      (req_rd),
    .mem_we      (mem_we),
    .mem_be      (mem_be),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .mem_pc      (mem_pc),
    .mem_rd      (mem_rd),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_rd      (rsp_rd),
    .rsp_exc     (rsp_exc),
    .rsp_badaddr (rsp_badaddr)
  );

  // Memory the DUT talks to: combinational read, byte-enabled write
  assign mem_rd = env_mem[mem_addr[WIDTH-3:0]];
  always @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) env_mem[mem_addr[WIDTH-3:0]][8*i +: 8] <= mem_wd[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference behaviour of one request, from the opcode's size/sign rules
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wdata,
                       input logic [4:0] rd, output rsp_t r, output bit st,
                       output logic [3:0] be, output logic [31:0] wd);
    int          size;
    bit          sgn;
    bit          legal;
    logic [63:0] v;
    logic [63:0] mask;
    size = 4; sgn = 0; legal = 1; st = 0;
    case (op)
      4'b0000: begin size = 1; sgn = 1; end
      4'b0001: begin size = 2; sgn = 1; end
      4'b0010: size = 4;
      4'b0100: size = 1;
      4'b0101: size = 2;
      4'b1000: begin size = 1; st = 1; end
      4'b1001: begin size = 2; st = 1; end
      4'b1010: begin size = 4; st = 1; end
      default: legal = 0;
    endcase
    if (!legal || a >= (32'd1 << WIDTH)) r.exc = 2'b11;
    else if ((a % size) != 0)            r.exc = st ? 2'b10 : 2'b01;
    else                                 r.exc = 2'b00;
    mask = (64'd1 << (8 * size)) - 64'd1;
    v = {32'h0, ref_mem[(a >> 2) % WORDS]} >> (8 * (a % 4));
    v = v & mask;
    if (sgn && v[8*size-1]) v = v | ~mask;
    if (r.exc != 2'b00 || st) begin
      r.data = 32'h0; r.rd = 5'd0;
    end else begin
      r.data = v[31:0]; r.rd = rd;
    end
    r.bad = (r.exc != 2'b00) ? a : 32'h0;
    be = 4'(((1 << size) - 1) << (a % 4));
    if (size == 1)      wd = {24'h0, wdata[7:0]} * 32'h01010101;
    else if (size == 2) wd = {16'h0, wdata[15:0]} * 32'h00010001;
    else                wd = wdata;
  endtask

  // One clock cycle: drive, predict, compare, then advance the model
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] wdata, input logic [4:0] rd, input logic rr);
    rsp_t        r;
    bit          st;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          exp_ready, acc, exp_we;
    logic [31:0] pc;
    pc = $urandom;
    @(negedge clk);
    req_valid = v; req_op = op; req_addr = a; req_wdata = wdata;
    req_rd = rd; req_pc = pc; rsp_ready = rr;
    #1;
    exp_ready = (pend.size() == 0) || rr;
    chk("req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
    if (pend.size() != 0) begin
      chk("rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("rsp_data", rsp_data, pend[0].data);
      chk("rsp_rd", {27'h0, rsp_rd}, {27'h0, pend[0].rd});
      chk("rsp_exc", {30'h0, rsp_exc}, {30'h0, pend[0].exc});
      chk("rsp_badaddr", rsp_badaddr, pend[0].bad);
    end else begin
      chk("rsp_valid", {31'h0, rsp_valid}, 32'h0);
    end
    model(op, a, wdata, rd, r, st, be, wd);
    acc    = v && exp_ready;
    exp_we = acc && st && (r.exc == 2'b00);
    chk("mem_we", {31'h0, mem_we}, {31'h0, exp_we});
    chk("mem_be", {28'h0, mem_be}, exp_we ? {28'h0, be} : 32'h0);
    if (exp_we) chk("mem_wd", mem_wd, wd);
    if (v) begin
      chk("mem_addr", mem_addr, a >> 2);
      chk("mem_pc", mem_pc, pc);
    end
    @(posedge clk);
    if (pend.size() != 0 && rr) void'(pend.pop_front());
    if (acc) pend.push_back(r);
    if (exp_we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[(a >> 2) % WORDS][8*i +: 8] = wd[8*i +: 8];
    end
  endtask

  task automatic idle();
    step(1'b0, 4'h0, 32'h0, 32'h0, 5'd0, 1'b1);
  endtask

  // Assert reset for one cycle with a store presented; nothing may be written
  task automatic reset_with_store(input logic [31:0] a, input logic [31:0] wdata);
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_op = 4'b1010; req_addr = a;
    req_wdata = wdata; rsp_ready = 1'b0;
    #1;
    chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
    chk("reset_mem_be", {28'h0, mem_be}, 32'h0);
    @(posedge clk);
    pend.delete();
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
  endtask

  initial begin
    logic [3:0] ops [8];
    ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101, 4'b1000, 4'b1001, 4'b1010};
    for (int i = 0; i < WORDS; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end

    // Reset values
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_rd", {27'h0, rsp_rd}, 32'h0);
    chk("rst_rsp_exc", {30'h0, rsp_exc}, 32'h0);
    chk("rst_rsp_badaddr", rsp_badaddr, 32'h0);
    reset = 1'b0;

    // Directed: word store, byte/half loads, byte store merge
    step(1'b1, 4'b1010, 32'h10, 32'hDEADBEEF, 5'd7, 1'b1);
    step(1'b1, 4'b1010, 32'h20, 32'h8070F0A5, 5'd1, 1'b1);
    step(1'b1, 4'b0000, 32'h21, 32'h0, 5'd2, 1'b1);
    step(1'b1, 4'b0100, 32'h21, 32'h0, 5'd3, 1'b1);
    step(1'b1, 4'b0001, 32'h22, 32'h0, 5'd4, 1'b1);
    step(1'b1, 4'b0101, 32'h20, 32'h0, 5'd5, 1'b1);
    step(1'b1, 4'b1010, 32'h1C, 32'h11223344, 5'd0, 1'b1);
    step(1'b1, 4'b1000, 32'h1E, 32'h00000033, 5'd0, 1'b1);
    step(1'b1, 4'b0010, 32'h1C, 32'h0, 5'd6, 1'b1);
    // Exceptions
    step(1'b1, 4'b0010, 32'h06, 32'h0, 5'd8, 1'b1);
    step(1'b1, 4'b1001, 32'h03, 32'hFFFF, 5'd9, 1'b1);
    step(1'b1, 4'b0111, 32'h40, 32'h0, 5'd10, 1'b1);
    step(1'b1, 4'b0010, 32'h1000, 32'h0, 5'd11, 1'b1);
    step(1'b1, 4'b1011, 32'h1001, 32'h0, 5'd12, 1'b1);
    idle();
    // Stall: response held, stores dropped, order kept after release
    step(1'b1, 4'b0010, 32'h20, 32'h0, 5'd13, 1'b1);
    step(1'b1, 4'b0010, 32'h1C, 32'h0, 5'd14, 1'b0);
    step(1'b1, 4'b1010, 32'h20, 32'hCAFEF00D, 5'd0, 1'b0);
    step(1'b1, 4'b1010, 32'h1C, 32'h12345678, 5'd0, 1'b0);
    step(1'b1, 4'b0010, 32'h1C, 32'h0, 5'd14, 1'b1);
    step(1'b1, 4'b0010, 32'h20, 32'h0, 5'd15, 1'b1);
    idle();
    // Reset while FULL with a store presented
    step(1'b1, 4'b0010, 32'h10, 32'h0, 5'd16, 1'b0);
    reset_with_store(32'h10, 32'h55555555);
    idle();
    step(1'b1, 4'b0010, 32'h10, 32'h0, 5'd17, 1'b1);
    idle();

    // Randomized traffic, addresses kept to a small window for reuse
    for (int n = 0; n < 3000; n++) begin
      logic [3:0]  op;
      logic [31:0] a;
      if ($urandom_range(0, 19) == 0) op = 4'($urandom);
      else op = ops[$urandom_range(0, 7)];
      if ($urandom_range(0, 24) == 0) a = $urandom;
      else a = {24'h0, 8'($urandom)};
      step($urandom_range(0, 9) < 8, op, a, $urandom, 5'($urandom),
           $urandom_range(0, 9) < 7);
    end
    repeat (2) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lsu
`default_nettype wire
